// File: rtl/stack_pkg.sv
// stack_pkg: shared definitions for the operand-stack execution stage.
// Holds the alu_op command encoding and the execution FSM state type.
package stack_pkg;

   // alu_op command encoding; values 7..15 are illegal
   localparam logic [3:0] ALU_NONE = 4'd0;
   localparam logic [3:0] ALU_AND  = 4'd1;
   localparam logic [3:0] ALU_OR   = 4'd2;
   localparam logic [3:0] ALU_ADD  = 4'd3;
   localparam logic [3:0] ALU_SUB  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_NOR  = 4'd6;

   // IDLE accepts commands; EXEC finishes a two-operand ALU op
   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

endpackage : stack_pkg

// File: rtl/stack_alu.sv
// stack_alu: purely combinational two-operand ALU for the operand stack.
// result_o = A op B (mod 2^WIDTH); illegal_o flags codes outside 1..6.
module stack_alu
   import stack_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [3:0]       op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             illegal_o
);

   logic slt_bit;

   assign slt_bit = ($signed(a_i) < $signed(b_i)) ? 1'b1 : 1'b0;

   // Select the operation result; unknown codes yield zero and raise illegal_o
   always_comb begin
      result_o  = '0;
      illegal_o = 1'b0;
      case (op_i)
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = a_i - b_i;
         ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, slt_bit};
         ALU_NOR: result_o = ~(a_i | b_i);
         default: illegal_o = 1'b1;
      endcase
   end

endmodule : stack_alu

// File: rtl/stack_exec.sv
// stack_exec: operand-stack execution stage (register-file LIFO + ALU).
// Push/pop finish in one cycle; ALU ops capture operands in IDLE and
// write back from EXEC. Optional feature macro: STACK_ERR_CLR_EN adds
// the err_clr port that clears the sticky error flag.
module stack_exec
   import stack_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
)
(
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       push,
   input  logic                       pop,
   input  logic [3:0]                 alu_op,
   input  logic [WIDTH-1:0]           imm,
   output logic [WIDTH-1:0]           top,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
`ifdef STACK_ERR_CLR_EN
   input  logic                       err_clr,
`endif
   output logic                       error
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   // Stack storage: not reset, only the pointer and flags are
   logic [WIDTH-1:0] mem_q [DEPTH];

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic             error_q, error_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       op_q, op_d;

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;

   logic [CW-1:0]    cnt_m1;
   logic [CW-1:0]    cnt_m2;
   logic             has_op;
   logic             one_cmd;
   logic             fault;
   logic [3:0]       alu_op_sel;
   logic [WIDTH-1:0] alu_result;
   logic             alu_illegal;

   assign cnt_m1  = count_q - CW'(1);
   assign cnt_m2  = count_q - CW'(2);
   assign has_op  = (alu_op != ALU_NONE);
   assign one_cmd = (push & ~pop & ~has_op) |
                    (~push & pop & ~has_op) |
                    (~push & ~pop & has_op);

   // In IDLE the ALU only screens the incoming code; in EXEC it computes
   assign alu_op_sel = (state_q == EXEC) ? op_q : alu_op;

   stack_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a_i       (a_q),
      .b_i       (b_q),
      .op_i      (alu_op_sel),
      .result_o  (alu_result),
      .illegal_o (alu_illegal)
   );

   // Outputs derive only from registered state
   assign cmd_ready = (state_q == IDLE);
   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign count     = count_q;
   assign error     = error_q;
   assign top       = empty ? '0 : mem_q[cnt_m1[AW-1:0]];

   // Command decode, fault detection and FSM next-state
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      fault   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = count_q[AW-1:0];
      wr_data = imm;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (!one_cmd) begin
                  fault = 1'b1;
               end else if (push) begin
                  if (full) begin
                     fault = 1'b1;
                  end else begin
                     wr_en   = 1'b1;
                     count_d = count_q + CW'(1);
                  end
               end else if (pop) begin
                  if (empty) begin
                     fault = 1'b1;
                  end else begin
                     count_d = cnt_m1;
                  end
               end else begin
                  if (alu_illegal || (count_q < CW'(2))) begin
                     fault = 1'b1;
                  end else begin
                     a_d     = mem_q[cnt_m2[AW-1:0]];
                     b_d     = mem_q[cnt_m1[AW-1:0]];
                     op_d    = alu_op;
                     state_d = EXEC;
                  end
               end
            end
         end
         EXEC: begin
            wr_en   = 1'b1;
            wr_addr = cnt_m2[AW-1:0];
            wr_data = alu_result;
            count_d = cnt_m1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef STACK_ERR_CLR_EN
      // A fault in the same cycle as err_clr keeps the flag set
      error_d = fault | (error_q & ~err_clr);
`else
      error_d = fault | error_q;
`endif
   end

   // Pointer, flag, FSM and captured-operand registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         error_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= ALU_NONE;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         error_q <= error_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
      end
   end

   // Stack entry write; suppressed while reset is held so an aborted op never lands
   always_ff @(posedge clock) begin
      if (wr_en && !reset) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

endmodule : stack_exec

// File: tb/tb_stack_exec.sv
// tb_stack_exec: directed self-checking bench for stack_exec (WIDTH=32, DEPTH=16).
// Honours STACK_ERR_CLR_EN when defined to exercise err_clr.
module tb_stack_exec;

   logic        clock;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        push;
   logic        pop;
   logic [3:0]  alu_op;
   logic [31:0] imm;
   logic [31:0] top;
   logic [4:0]  count;
   logic        empty;
   logic        full;
   logic        error;
`ifdef STACK_ERR_CLR_EN
   logic        err_clr;
`endif

   int checks = 0;
   int errors = 0;

   stack_exec #(
      .WIDTH (32),
      .DEPTH (16)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .push      (push),
      .pop       (pop),
      .alu_op    (alu_op),
      .imm       (imm),
      .top       (top),
      .count     (count),
      .empty     (empty),
      .full      (full),
`ifdef STACK_ERR_CLR_EN
      .err_clr   (err_clr),
`endif
      .error     (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Present one command for one edge, then idle the inputs
   task automatic send(input logic v, input logic p, input logic q,
                       input logic [3:0] op, input logic [31:0] val);
      cmd_valid = v;
      push      = p;
      pop       = q;
      alu_op    = op;
      imm       = val;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      alu_op    = 4'd0;
      imm       = 32'h0;
   endtask

   task automatic do_push(input logic [31:0] val);
      send(1'b1, 1'b1, 1'b0, 4'd0, val);
   endtask

   // ALU op: ready drops for the EXEC cycle, result lands on the next edge
   task automatic do_alu(input logic [3:0] op, input string tag);
      send(1'b1, 1'b0, 1'b0, op, 32'h0);
      check({tag, "_ready_low"}, {31'b0, cmd_ready}, 32'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      alu_op    = 4'd0;
      imm       = 32'h0;
`ifdef STACK_ERR_CLR_EN
      err_clr   = 1'b0;
`endif
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state
      check("rst_count", {27'b0, count}, 32'd0);
      check("rst_empty", {31'b0, empty}, 32'd1);
      check("rst_full",  {31'b0, full},  32'd0);
      check("rst_top",   top,            32'd0);
      check("rst_error", {31'b0, error}, 32'd0);
      check("rst_ready", {31'b0, cmd_ready}, 32'd1);

      // Push 5 then 7
      do_push(32'd5);
      check("push5_top", top, 32'd5);
      do_push(32'd7);
      check("push7_count", {27'b0, count}, 32'd2);
      check("push7_top",   top,            32'd7);
      check("push7_empty", {31'b0, empty}, 32'd0);
      check("push7_error", {31'b0, error}, 32'd0);

      // Command without valid is ignored
      send(1'b0, 1'b1, 1'b0, 4'd0, 32'h55);
      check("novalid_count", {27'b0, count}, 32'd2);

      // ADD wrap-around
      do_reset();
      do_push(32'hFFFF_FFFF);
      do_push(32'd1);
      send(1'b1, 1'b0, 1'b0, 4'd3, 32'h0);
      check("add_ready_low",  {31'b0, cmd_ready}, 32'd0);
      check("add_count_exec", {27'b0, count},     32'd2);
      @(posedge clock);
      #1;
      check("add_ready_back", {31'b0, cmd_ready}, 32'd1);
      check("add_top",        top,                32'd0);
      check("add_count",      {27'b0, count},     32'd1);

      // SUB then SLT with negative operand
      do_reset();
      do_push(32'd3);
      do_push(32'd5);
      do_alu(4'd4, "sub");
      check("sub_top", top, 32'hFFFF_FFFE);
      check("sub_count", {27'b0, count}, 32'd1);
      do_push(32'hFFFF_FFFF);
      do_push(32'd1);
      do_alu(4'd5, "slt");
      check("slt_top",   top,            32'd1);
      check("slt_count", {27'b0, count}, 32'd2);
      send(1'b1, 1'b0, 1'b1, 4'd0, 32'h0);
      check("pop_top", top, 32'hFFFF_FFFE);

      // AND / OR / NOR chain
      do_reset();
      do_push(32'h0000_F0F0);
      do_push(32'h0000_FF00);
      do_alu(4'd1, "and");
      check("and_top", top, 32'h0000_F000);
      do_push(32'h0000_000F);
      do_alu(4'd2, "or");
      check("or_top", top, 32'h0000_F00F);
      do_push(32'h0);
      do_alu(4'd6, "nor");
      check("nor_top", top, 32'hFFFF_0FF0);
      check("nor_error", {31'b0, error}, 32'd0);

      // Fill to DEPTH, then overflow
      do_reset();
      for (int i = 0; i < 16; i++) begin
         do_push(32'h100 + i);
      end
      check("fill_full",  {31'b0, full},  32'd1);
      check("fill_count", {27'b0, count}, 32'd16);
      check("fill_top",   top,            32'h10F);
      do_push(32'hDEAD);
      check("ovf_error", {31'b0, error}, 32'd1);
      check("ovf_count", {27'b0, count}, 32'd16);
      check("ovf_top",   top,            32'h10F);

      // Underflow
      do_reset();
      send(1'b1, 1'b0, 1'b1, 4'd0, 32'h0);
      check("udf_error", {31'b0, error}, 32'd1);
      check("udf_count", {27'b0, count}, 32'd0);

      // Push and pop together
      do_reset();
      send(1'b1, 1'b1, 1'b1, 4'd0, 32'h9);
      check("pushpop_error", {31'b0, error}, 32'd1);
      check("pushpop_count", {27'b0, count}, 32'd0);

      // No command bits set
      do_reset();
      send(1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
      check("nocmd_error", {31'b0, error}, 32'd1);

      // Illegal alu_op 9 does not enter EXEC
      do_reset();
      do_push(32'd2);
      do_push(32'd3);
      send(1'b1, 1'b0, 1'b0, 4'd9, 32'h0);
      check("op9_error", {31'b0, error},     32'd1);
      check("op9_ready", {31'b0, cmd_ready}, 32'd1);
      check("op9_count", {27'b0, count},     32'd2);
      check("op9_top",   top,                32'd3);

      // ALU with a single entry
      do_reset();
      do_push(32'd4);
      send(1'b1, 1'b0, 1'b0, 4'd3, 32'h0);
      check("alu1_error", {31'b0, error},     32'd1);
      check("alu1_ready", {31'b0, cmd_ready}, 32'd1);
      check("alu1_count", {27'b0, count},     32'd1);
      check("alu1_top",   top,                32'd4);

`ifdef STACK_ERR_CLR_EN
      // err_clr clears the sticky flag
      err_clr = 1'b1;
      @(posedge clock);
      #1;
      err_clr = 1'b0;
      check("errclr_error", {31'b0, error}, 32'd0);
      // Fault coinciding with err_clr keeps error set
      err_clr = 1'b1;
      send(1'b1, 1'b1, 1'b1, 4'd0, 32'h0);
      err_clr = 1'b0;
      check("errclr_fault_wins", {31'b0, error}, 32'd1);
`endif

      // Reset during EXEC aborts the op
      do_reset();
      do_push(32'd10);
      do_push(32'd20);
      send(1'b1, 1'b0, 1'b0, 4'd3, 32'h0);
      check("abort_ready_low", {31'b0, cmd_ready}, 32'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("abort_count", {27'b0, count},     32'd0);
      check("abort_ready", {31'b0, cmd_ready}, 32'd1);
      check("abort_empty", {31'b0, empty},     32'd1);
      check("abort_nowrite", dut.mem_q[0],     32'd10);
      do_push(32'd77);
      check("abort_push_top", top, 32'd77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

endmodule : tb_stack_exec

// File: doc/stack_exec.md
# stack_exec

Operand-stack execution stage for the stack machine, directly downstream of the control unit. Consumes the decoded `push`/`pop`/`alu_op` command plus an immediate, keeps a register-file LIFO with pointer, full/empty tracking and sticky error, and evaluates two-operand ALU ops in place on the top two entries. Exposes the top-of-stack value to the rest of the datapath.

## Interface
- `WIDTH`, 32, data width of stack entries and immediate
- `DEPTH`, 16, number of stack entries (power of two, ≥ 2)

- `clock` in 1, rising-edge clock
- `reset` in 1, asynchronous, active-high; clears pointer, FSM, flags
- `cmd_valid` in 1, command present this cycle
- `cmd_ready` out 1, stage can accept a command
- `push` in 1, push `imm`
- `pop` in 1, discard top entry
- `alu_op` in 4, ALU command; 0 = none
- `imm` in WIDTH, value pushed by `push`
- `top` out WIDTH, current top entry; 0 when empty
- `count` out $clog2(DEPTH+1), number of valid entries
- `empty` out 1, `count == 0`
- `full` out 1, `count == DEPTH`
- `error` out 1, sticky fault flag
- `err_clr` in 1, clears `error` (only with `STACK_ERR_CLR_EN`)

## Operation
- Command accepted when `cmd_valid && cmd_ready`; nothing changes otherwise.
- Legal commands: exactly one of {`push`, `pop`, `alu_op != 0`}. Anything else (none set, two or more set): command dropped, `error` set.
- `alu_op` encoding: 1 AND, 2 OR, 3 ADD, 4 SUB, 5 SLT, 6 NOR; 7–15 illegal → dropped, `error` set.
- PUSH: `stack[count] <= imm`, `count+1`. On `full`: dropped, `error` set (overflow).
- POP: `count-1`. On `empty`: dropped, `error` set (underflow).
- ALU: A = `stack[count-2]`, B = `stack[count-1]`; result written to `stack[count-2]`, `count-1`. With `count < 2`: dropped, `error` set, no FSM transition.
- Arithmetic mod 2^WIDTH; SUB = A − B; SLT = signed A < B → 1 else 0, zero-extended.
- FSM states: IDLE, EXEC.
  - IDLE: `cmd_ready = 1`. Push/pop complete here. Legal ALU accept → capture A, B, op into registers, go EXEC.
  - EXEC: `cmd_ready = 0`; compute from captured operands, write result, decrement `count`, return to IDLE.
- Stack contents not cleared by reset; only pointer and flags. Entries above `count` are don't-care.

## Timing
- Reset values: `count = 0`, `empty = 1`, `full = 0`, `top = 0`, `error = 0`, `cmd_ready = 1`, FSM = IDLE. Reset mid-EXEC aborts the op; no write occurs.
- PUSH/POP: 1-cycle latency; `top`, `count`, flags reflect result the cycle after accept.
- ALU: 2-cycle latency; accept edge → EXEC; next edge writes; `top` shows result after the second edge. Throughput one ALU op per 2 cycles.
- `top`, `empty`, `full`, `count` are registered-state derived (no combinational path from command inputs).
- `error` rises the cycle after the faulting accept and holds until reset (or `err_clr`).

## Configuration
- `STACK_ERR_CLR_EN` defined: `err_clr` port exists; `err_clr` high at a clock edge clears `error`; a new fault in the same cycle wins (error stays 1).
- Undefined: no `err_clr` port; `error` clears only by `reset`.

## Structure
- Package `stack_pkg`: `alu_op` encoding constants (`ALU_NONE`, `ALU_AND` … `ALU_NOR`), FSM state typedef (IDLE, EXEC).
- Sub-module `stack_alu`: purely combinational, inputs A, B, op; output result, `illegal` flag. The parent owns all state.

## Test plan
- Reset, push 5 then 7 → `count=2`, `top=7`, `empty=0`, `error=0`.
- Push 0xFFFF_FFFF, push 1, ALU ADD → `cmd_ready` low one cycle, then `top=0`, `count=1`.
- Push 3, push 5, SUB → `top=0xFFFF_FFFE`; push −1, push 1, SLT → `top=1`.
- Push `DEPTH` values → `full=1`; one more push → `error=1`, `count=DEPTH`, `top` unchanged. Pop on empty after reset → `error=1`, `count=0`.
- `push` and `pop` together, and `alu_op=9` → dropped, `error=1`; with `STACK_ERR_CLR_EN`, `err_clr` pulse → `error=0`.
- Assert `reset` during EXEC of ADD → `count=0`, FSM IDLE, `cmd_ready=1`, no result written.
